// File: rtl/pe_pkg.sv
// Shared types and helpers for the feature-map scratchpad loader.
package pe_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} fmap_state_e;

  // Address arithmetic is done at this width, then cast down to the pointer width.
  localparam int unsigned CalcWidth = 32;

  // Operands are assumed already reduced (< size), so one conditional subtract suffices.
  function automatic logic [CalcWidth-1:0] mod_add(input logic [CalcWidth-1:0] a,
                                                   input logic [CalcWidth-1:0] b,
                                                   input logic [CalcWidth-1:0] size);
    logic [CalcWidth-1:0] sum;
    sum = a + b;
    if (sum >= size) sum = sum - size;
    return sum;
  endfunction

  function automatic logic [CalcWidth-1:0] mod_inc(input logic [CalcWidth-1:0] a,
                                                   input logic [CalcWidth-1:0] size);
    return mod_add(a, 32'd1, size);
  endfunction

endpackage

// File: rtl/fmap_spad_ram.sv
// Scratchpad storage: one write port, one registered read port, read-old-data on collision.
module fmap_spad_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 12,
  parameter int unsigned AW         = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Both accesses are non-blocking on the same edge, so a colliding read sees the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fmap_spad_loader.sv
// Feature-map scratchpad loader: full/shift bursts into a circular pad, windowed reads.
// Optional FMAP_ZERO_PAD_EN adds a pad_zero input that writes zero words into a burst.
module fmap_spad_loader
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned PARA_WIDTH  = 8,
  parameter int unsigned IF_PAD_SIZE = 12,
  parameter int unsigned ADDR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PARA_WIDTH-1:0] S,
  input  logic [PARA_WIDTH-1:0] U,
  input  logic [PARA_WIDTH-1:0] q,
  input  logic                  start_config,
  input  logic                  start_feature_load,
  input  logic                  load_full_cloumn,
  input  logic [DATA_WIDTH-1:0] feature_in,
  input  logic                  feature_in_en,
  output logic                  fmap_pe_ready,
`ifdef FMAP_ZERO_PAD_EN
  input  logic                  pad_zero,
`endif
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  shift_finish_flg,
  output logic                  window_valid,
  output logic                  cfg_err
);

  localparam int unsigned PtrW  = (IF_PAD_SIZE > 1) ? $clog2(IF_PAD_SIZE) : 1;
  localparam int unsigned ProdW = 2 * PARA_WIDTH;

  fmap_state_e state_q, state_d;
  logic [PARA_WIDTH-1:0] s_q, s_d, u_q, u_d, qc_q, qc_d;
  logic                  cfg_err_q, cfg_err_d;
  logic [PtrW-1:0]       base_q, base_d, wr_ptr_q, wr_ptr_d;
  logic [ProdW-1:0]      len_q, len_d, cnt_q, cnt_d;
  logic                  shift_q, shift_d;
  logic                  window_valid_q, window_valid_d;
  logic                  rd_valid_q, rd_zero_q;

  logic [ProdW-1:0]      sq_cfg, uq_cfg, sq_in, burst_len;
  logic                  cfg_bad_in;
  logic                  pad_xfer, stream_xfer, xfer;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd_oob;
  logic [PtrW-1:0]       rd_phys;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign sq_cfg = {{PARA_WIDTH{1'b0}}, s_q} * {{PARA_WIDTH{1'b0}}, qc_q};
  assign uq_cfg = {{PARA_WIDTH{1'b0}}, u_q} * {{PARA_WIDTH{1'b0}}, qc_q};
  assign sq_in  = {{PARA_WIDTH{1'b0}}, S} * {{PARA_WIDTH{1'b0}}, q};

  assign cfg_bad_in = (S == '0) || (U == '0) || (q == '0) || (U > S) ||
                      (32'(sq_in) > IF_PAD_SIZE);

`ifdef FMAP_ZERO_PAD_EN
  // A pad cycle takes the write port, so the stream is held off for that cycle.
  assign pad_xfer      = (state_q == StLoad) && pad_zero;
  assign fmap_pe_ready = (state_q == StLoad) && !pad_zero;
`else
  assign pad_xfer      = 1'b0;
  assign fmap_pe_ready = (state_q == StLoad);
`endif

  assign stream_xfer = fmap_pe_ready && feature_in_en;
  assign xfer        = stream_xfer || pad_xfer;
  assign wdata       = pad_xfer ? '0 : feature_in;

  always_comb begin
    state_d        = state_q;
    s_d            = s_q;
    u_d            = u_q;
    qc_d           = qc_q;
    cfg_err_d      = cfg_err_q;
    base_d         = base_q;
    wr_ptr_d       = wr_ptr_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    window_valid_d = window_valid_q;
    burst_len      = load_full_cloumn ? sq_cfg : uq_cfg;

    case (state_q)
      StIdle: begin
        if (start_config) begin
          s_d       = S;
          u_d       = U;
          qc_d      = q;
          cfg_err_d = cfg_bad_in;
        end
        // A zero-length burst (unconfigured after reset) could never complete, so refuse it.
        if (start_feature_load && !cfg_err_q && (load_full_cloumn || window_valid_q) &&
            (burst_len != '0)) begin
          state_d = StLoad;
          len_d   = burst_len;
          cnt_d   = '0;
          shift_d = !load_full_cloumn;
          if (load_full_cloumn) begin
            wr_ptr_d       = '0;
            base_d         = '0;
            window_valid_d = 1'b0;
          end else begin
            wr_ptr_d = PtrW'(mod_add(32'(base_q), 32'(sq_cfg), IF_PAD_SIZE));
          end
        end
      end
      StLoad: begin
        if (xfer) begin
          wr_ptr_d = PtrW'(mod_inc(32'(wr_ptr_q), IF_PAD_SIZE));
          cnt_d    = cnt_q + ProdW'(1);
          if (cnt_q + ProdW'(1) == len_q) begin
            state_d        = StDone;
            window_valid_d = 1'b1;
            if (shift_q) base_d = PtrW'(mod_add(32'(base_q), 32'(uq_cfg), IF_PAD_SIZE));
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign rd_oob  = (32'(rd_addr) >= 32'(sq_cfg)) || (32'(rd_addr) >= IF_PAD_SIZE);
  assign rd_phys = PtrW'(mod_add(32'(base_q), 32'(rd_addr), IF_PAD_SIZE));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      s_q            <= '0;
      u_q            <= '0;
      qc_q           <= '0;
      cfg_err_q      <= 1'b0;
      base_q         <= '0;
      wr_ptr_q       <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      shift_q        <= 1'b0;
      window_valid_q <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_zero_q      <= 1'b1;
    end else begin
      state_q        <= state_d;
      s_q            <= s_d;
      u_q            <= u_d;
      qc_q           <= qc_d;
      cfg_err_q      <= cfg_err_d;
      base_q         <= base_d;
      wr_ptr_q       <= wr_ptr_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      window_valid_q <= window_valid_d;
      rd_valid_q     <= rd_en;
      if (rd_en) rd_zero_q <= rd_oob;
    end
  end

  fmap_spad_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (IF_PAD_SIZE),
    .AW        (PtrW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (xfer),
    .waddr_i(wr_ptr_q),
    .wdata_i(wdata),
    .re_i   (rd_en && !rd_oob),
    .raddr_i(rd_phys),
    .rdata_o(ram_rdata)
  );

  assign rd_data          = rd_zero_q ? '0 : ram_rdata;
  assign rd_valid         = rd_valid_q;
  assign shift_finish_flg = (state_q == StDone);
  assign window_valid     = window_valid_q;
  assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_fmap_spad_loader.sv
// Directed bench for fmap_spad_loader with a logical-window model and a read scoreboard.
module tb_fmap_spad_loader;

  localparam int DW = 16;
  localparam int PW = 8;
  localparam int PAD = 12;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] S, U, q;
  logic          start_config, start_feature_load, load_full_cloumn;
  logic [DW-1:0] feature_in;
  logic          feature_in_en;
  logic          fmap_pe_ready;
  logic          pad_zero;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid, shift_finish_flg, window_valid, cfg_err;

  int checks = 0;
  int failures = 0;
  int cfg_uq = 0;
  logic [DW-1:0] model[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  fmap_spad_loader #(
    .DATA_WIDTH (DW),
    .PARA_WIDTH (PW),
    .IF_PAD_SIZE(PAD),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .S                 (S),
    .U                 (U),
    .q                 (q),
    .start_config      (start_config),
    .start_feature_load(start_feature_load),
    .load_full_cloumn  (load_full_cloumn),
    .feature_in        (feature_in),
    .feature_in_en     (feature_in_en),
    .fmap_pe_ready     (fmap_pe_ready),
`ifdef FMAP_ZERO_PAD_EN
    .pad_zero          (pad_zero),
`endif
    .rd_en             (rd_en),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .shift_finish_flg  (shift_finish_flg),
    .window_valid      (window_valid),
    .cfg_err           (cfg_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic configure(input int s, input int u, input int qq);
    S = PW'(s);
    U = PW'(u);
    q = PW'(qq);
    start_config = 1'b1;
    tick();
    start_config = 1'b0;
    if (!(s == 0 || u == 0 || qq == 0 || u > s || s * qq > PAD)) cfg_uq = u * qq;
  endtask

  task automatic do_read(input int addr, input string tag);
    logic [DW-1:0] e;
    logic [DW-1:0] got;
    e = (addr < model.size()) ? model[addr] : '0;
    exp_q.push_back(e);
    rd_en = 1'b1;
    rd_addr = AW'(addr);
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    got = exp_q.pop_front();
    check(tag, 32'(rd_data), 32'(got));
  endtask

  // Streams n words starting at value 'first'; toggle drops feature_in_en every other cycle.
  task automatic run_burst(input bit full, input int n, input int first, input bit toggle);
    int sent;
    int cyc;
    bit en_phase;
    bit took;
    bit early;
    sent = 0;
    cyc = 0;
    early = 1'b0;
    en_phase = !toggle;
    if (full) model.delete();
    else for (int i = 0; i < cfg_uq; i++) void'(model.pop_front());
    start_feature_load = 1'b1;
    load_full_cloumn = full;
    tick();
    start_feature_load = 1'b0;
    while (sent < n && cyc < 200) begin
      feature_in = DW'(first + sent);
      feature_in_en = en_phase;
      took = feature_in_en && fmap_pe_ready;
      tick();
      if (took) begin
        model.push_back(DW'(first + sent));
        sent++;
      end
      if (sent < n) early |= shift_finish_flg;
      if (toggle) en_phase = !en_phase;
      cyc++;
    end
    feature_in_en = 1'b0;
    check("burst_len", 32'(sent), 32'(n));
    check("no_early_pulse", 32'(early), 32'd0);
    check("finish_pulse", 32'(shift_finish_flg), 32'd1);
    check("window_valid_set", 32'(window_valid), 32'd1);
    tick();
    check("pulse_one_cycle", 32'(shift_finish_flg), 32'd0);
    check("ready_low_idle", 32'(fmap_pe_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    S = '0; U = '0; q = '0;
    start_config = 1'b0;
    start_feature_load = 1'b0;
    load_full_cloumn = 1'b0;
    feature_in = '0;
    feature_in_en = 1'b0;
    pad_zero = 1'b0;
    rd_en = 1'b0;
    rd_addr = '0;
    tick();
    tick();
    check("rst_ready", 32'(fmap_pe_ready), 32'd0);
    check("rst_finish", 32'(shift_finish_flg), 32'd0);
    check("rst_window_valid", 32'(window_valid), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b1;
    tick();

    // Full load of 1..12
    configure(12, 1, 1);
    check("cfg_ok", 32'(cfg_err), 32'd0);
    run_burst(1'b1, 12, 1, 1'b0);
    for (int a = 0; a < 12; a++) do_read(a, "full_rd");

    // One-word shift load, window slides by one
    run_burst(1'b0, 1, 13, 1'b0);
    do_read(0, "shift_rd0");
    do_read(11, "shift_rd11");
    do_read(12, "oob_rd12");

    // Twelve more shift loads wrap the circular pad completely
    for (int k = 0; k < 12; k++) run_burst(1'b0, 1, 14 + k, 1'b0);
    do_read(0, "wrap_rd0");
    do_read(5, "wrap_rd5");
    do_read(11, "wrap_rd11");

    // Illegal configurations
    configure(5, 1, 3);
    check("cfg_err_prod", 32'(cfg_err), 32'd1);
    start_feature_load = 1'b1;
    load_full_cloumn = 1'b1;
    tick();
    start_feature_load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("illegal_ready_low", 32'(fmap_pe_ready), 32'd0);
      tick();
    end
    configure(2, 3, 1);
    check("cfg_err_u_gt_s", 32'(cfg_err), 32'd1);
    configure(12, 1, 1);
    check("cfg_err_cleared", 32'(cfg_err), 32'd0);

    // Backpressure: feature_in_en toggles every cycle
    run_burst(1'b1, 12, 101, 1'b1);
    do_read(0, "bp_rd0");
    do_read(6, "bp_rd6");
    do_read(11, "bp_rd11");

    // Reset in the middle of a burst
    model.delete();
    start_feature_load = 1'b1;
    load_full_cloumn = 1'b1;
    tick();
    start_feature_load = 1'b0;
    begin
      int sent;
      int cyc;
      sent = 0;
      cyc = 0;
      while (sent < 6 && cyc < 50) begin
        feature_in = DW'(201 + sent);
        feature_in_en = 1'b1;
        if (fmap_pe_ready) sent++;
        tick();
        cyc++;
      end
      check("abort_sent6", 32'(sent), 32'd6);
    end
    feature_in_en = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort_ready", 32'(fmap_pe_ready), 32'd0);
    check("abort_no_pulse", 32'(shift_finish_flg), 32'd0);
    check("abort_window_valid", 32'(window_valid), 32'd0);
    tick();
    check("abort_no_pulse_late", 32'(shift_finish_flg), 32'd0);
    check("abort_idle", 32'(fmap_pe_ready), 32'd0);
    do_read(0, "abort_rd0");

`ifdef FMAP_ZERO_PAD_EN
    // Zero padding: one pad cycle, then stream 1..3
    configure(4, 1, 1);
    model.delete();
    start_feature_load = 1'b1;
    load_full_cloumn = 1'b1;
    tick();
    start_feature_load = 1'b0;
    pad_zero = 1'b1;
    feature_in = DW'(99);
    feature_in_en = 1'b1;
    check("pad_ready_low", 32'(fmap_pe_ready), 32'd0);
    tick();
    pad_zero = 1'b0;
    model.push_back('0);
    for (int k = 1; k <= 3; k++) begin
      feature_in = DW'(k);
      check("pad_stream_ready", 32'(fmap_pe_ready), 32'd1);
      tick();
      model.push_back(DW'(k));
    end
    feature_in_en = 1'b0;
    check("pad_finish", 32'(shift_finish_flg), 32'd1);
    tick();
    for (int a = 0; a < 4; a++) do_read(a, "pad_rd");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fmap_spad_loader.md
FMAP_SPAD_LOADER -- requirements
Module: fmap_spad_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, feature word width.
REQ-002 SHALL have parameter PARA_WIDTH, default 8, width of S/U/q config fields.
REQ-003 SHALL have parameter IF_PAD_SIZE, default 12, scratchpad depth in words.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8, logical read address width; IF_PAD_SIZE <= 2**ADDR_WIDTH.
REQ-005 SHALL have ports, one per line, name direction width meaning, clock and reset first:
 clk  in  1  single clock, all logic on rising edge.
 rst  in  1  synchronous reset, active-low.
 S  in  PARA_WIDTH  window span per channel, in words.
 U  in  PARA_WIDTH  stride, in words per channel per shift.
 q  in  PARA_WIDTH  channel count.
 start_config  in  1  latch S/U/q.
 start_feature_load  in  1  begin load burst.
 load_full_cloumn  in  1  sampled with start: 1 = full load, 0 = shift load.
 feature_in  in  DATA_WIDTH  stream data.
 feature_in_en  in  1  stream valid.
 fmap_pe_ready  out  1  stream ready; a word transfers when feature_in_en & fmap_pe_ready.
 rd_en  in  1  read request.
 rd_addr  in  ADDR_WIDTH  logical window address.
 rd_data  out  DATA_WIDTH  read data.
 rd_valid  out  1  rd_data valid.
 shift_finish_flg  out  1  one-cycle pulse, burst complete.
 window_valid  out  1  scratchpad holds a complete window.
 cfg_err  out  1  latched configuration illegal.

Function
REQ-006 SHALL implement states IDLE, LOAD, DONE.
REQ-007 SHALL latch S/U/q in IDLE on start_config; start_config in LOAD/DONE ignored.
REQ-008 SHALL set cfg_err when latched S=0, U=0, q=0, U>S, or S*q>IF_PAD_SIZE (product computed 2*PARA_WIDTH wide); cleared by next legal config.
REQ-009 SHALL go IDLE->LOAD on start_feature_load when cfg_err=0, and for shift loads also window_valid=1; otherwise stay IDLE.
REQ-010 SHALL set burst length N = S*q for full load, U*q for shift load, captured on entry to LOAD.
REQ-011 SHALL drive fmap_pe_ready=1 only in LOAD; each transfer writes one word at physical address wr_ptr, wr_ptr wraps mod IF_PAD_SIZE.
REQ-012 SHALL, on full load, start wr_ptr and base at 0; on shift load, start wr_ptr at (base + S*q) mod IF_PAD_SIZE and advance base by U*q mod IF_PAD_SIZE at burst end.
REQ-013 SHALL, after the Nth transfer, enter DONE for exactly one cycle, pulse shift_finish_flg in that cycle, set window_valid, and return to IDLE.
REQ-014 SHALL clear window_valid on entry to LOAD for a full load, keep it during a shift load.
REQ-015 SHALL serve reads in any state: physical = (base + rd_addr) mod IF_PAD_SIZE, rd_data/rd_valid registered, latency 1 cycle; rd_addr >= S*q returns 0 with rd_valid=1.
REQ-016 SHALL return old data when a read and a write hit the same physical address in one cycle.
REQ-017 SHALL ignore start_feature_load while in LOAD or DONE.

Reset
REQ-018 SHALL on rst=0 at a clock edge force IDLE, wr_ptr=0, base=0, fmap_pe_ready=0, shift_finish_flg=0, window_valid=0, cfg_err=0, rd_valid=0, rd_data=0, S/U/q registers=0; scratchpad contents unspecified.
REQ-019 SHALL abort a burst in progress on reset, no shift_finish_flg issued.

Configuration
REQ-020 SHALL support macro FMAP_ZERO_PAD_EN: when defined, add input pad_zero (1 bit); in LOAD, pad_zero=1 writes a zero word and counts as a transfer without consuming feature_in (fmap_pe_ready=0 that cycle); when undefined, no pad_zero port and only stream transfers write.

Structure
REQ-021 SHALL place state enum, width constants and the mod-IF_PAD_SIZE increment helper in shared package pe_pkg.
REQ-022 SHALL instantiate one sub-module fmap_spad_ram: 1 write / 1 registered read port, IF_PAD_SIZE x DATA_WIDTH, read-old-data on collision.

Verification
REQ-023 Full load: S=12,U=1,q=1, stream 1..12 -> shift_finish_flg pulse after 12th transfer, window_valid=1, reads addr 0..11 return 1..12 one cycle later.
REQ-024 Shift load: after REQ-023, shift load word 13 -> addr 0 returns 2, addr 11 returns 13, base=1.
REQ-025 Wrap: 12 further shift loads words 14..25 -> addr 0 returns 14, addr 11 returns 25.
REQ-026 Illegal config: S=5,q=3 (15>12) -> cfg_err=1, start_feature_load ignored, fmap_pe_ready stays 0.
REQ-027 Backpressure/reset: feature_in_en toggles every cycle during 12-word load -> exactly 12 writes; rst=0 after 6th word -> IDLE, no pulse, window_valid=0.
REQ-028 FMAP_ZERO_PAD_EN: S=4,q=1, pad_zero on cycle 1 then stream 1..3 -> reads return 0,1,2,3.
